// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_pkg
// Description : Shared widths, mem_arb state encoding and arbitration limits.
// Revision    : 1.0  initial release
// ============================================================================
package sisc_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    // Consecutive data grants allowed before a waiting fetch must win.
    localparam logic [1:0] STREAK_LIMIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage : sisc_pkg
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb
// Description : Two-port (fetch/data) arbiter onto one single-port memory.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arb
    import sisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    arb_state_e        r_state;
    logic              r_grant_d;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_streak;
    logic              r_m_en;
    logic              r_if_ack;
    logic              r_d_ack;

    logic              w_any_req;
    logic              w_grant_d;

    assign w_any_req = if_req | d_req;
    // Data has priority unless it has already won STREAK_LIMIT times in a row.
    assign w_grant_d = d_req & (~if_req | (r_streak != STREAK_LIMIT));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state   <= IDLE;
            r_grant_d <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_streak  <= 2'd0;
            r_m_en    <= 1'b0;
            r_if_ack  <= 1'b0;
            r_d_ack   <= 1'b0;
        end else begin
            r_m_en   <= 1'b0;
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state   <= ACC;
                        r_m_en    <= 1'b1;
                        r_grant_d <= w_grant_d;
                        if (w_grant_d) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                            if (r_streak < STREAK_LIMIT) begin
                                r_streak <= r_streak + 2'd1;
                            end
                        end else begin
                            r_addr   <= if_addr;
                            r_we     <= 1'b0;
                            r_wdata  <= '0;
                            r_streak <= 2'd0;
                        end
                    end
                end
                ACC: begin
                    r_state  <= RESP;
                    r_if_ack <= ~r_grant_d;
                    r_d_ack  <= r_grant_d;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_en    = r_m_en;
    assign m_we    = r_m_en & r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

    // Memory read data only arrives during RESP, so it is steered through, gated by the ack.
    assign if_ack   = r_if_ack;
    assign d_ack    = r_d_ack;
    assign if_rdata = r_if_ack ? m_rdata : '0;
    assign d_rdata  = (r_d_ack & ~r_we) ? m_rdata : '0;

    assign busy = (r_state != IDLE);

endmodule : mem_arb
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb
// Description : Directed, table-driven self-checking bench for mem_arb.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arb;
    import sisc_pkg::*;

    logic              clk;
    logic              rst_f;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;

    logic              mem_clear;
    logic [DATA_W-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [31:0] d_wdata;
        logic        exp_d;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    mem_arb dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: read data valid the cycle after m_en.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h30] <= 32'hA5A5A5A5;
            mem[8'h40] <= 32'h0BADF00D;
            m_rdata    <= 32'h0;
        end else if (m_en) begin
            if (m_we) mem[m_addr[7:0]] <= m_wdata;
            m_rdata <= mem[m_addr[7:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        @(negedge clk);
        if_req  = v.if_req;
        if_addr = v.if_addr;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        @(posedge clk); #1;
        check($sformatf("v%0d m_en", n), {31'b0, m_en}, 32'd1);
        check($sformatf("v%0d m_we", n), {31'b0, m_we}, {31'b0, v.exp_we});
        check($sformatf("v%0d m_addr", n), {16'b0, m_addr}, {16'b0, v.exp_addr});
        if (v.exp_we) check($sformatf("v%0d m_wdata", n), m_wdata, v.exp_wdata);
        check($sformatf("v%0d early ack", n), {30'b0, if_ack, d_ack}, 32'd0);
        check($sformatf("v%0d busy acc", n), {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        check($sformatf("v%0d m_en resp", n), {31'b0, m_en}, 32'd0);
        check($sformatf("v%0d acks", n), {30'b0, if_ack, d_ack},
              v.exp_d ? 32'd1 : 32'd2);
        check($sformatf("v%0d if_rdata", n), if_rdata, v.exp_d ? 32'h0 : v.exp_rdata);
        check($sformatf("v%0d d_rdata", n), d_rdata, v.exp_d ? v.exp_rdata : 32'h0);
        @(negedge clk);
        drop_reqs();
        @(posedge clk); #1;
        check($sformatf("v%0d busy idle", n), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d acks idle", n), {30'b0, if_ack, d_ack}, 32'd0);
    endtask

    initial begin : main
        logic [1:0] exp_src [6];
        int         got;
        int         cyc;
        int         last_f;

        //           if_req if_addr  d_req d_we d_addr   d_wdata       exp_d addr     we    wdata         rdata
        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 16'h0010, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 32'h12345678, 1'b1, 16'h0020, 1'b1, 32'h12345678, 32'h0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 32'h0,        1'b1, 16'h0020, 1'b0, 32'h0,        32'h12345678};
        vecs[3] = '{1'b1, 16'h0030, 1'b1, 1'b0, 16'h0040, 32'h0,        1'b0, 16'h0030, 1'b0, 32'h0,        32'hA5A5A5A5};
        vecs[4] = '{1'b1, 16'h0010, 1'b1, 1'b1, 16'h0050, 32'hCAFEF00D, 1'b1, 16'h0050, 1'b1, 32'hCAFEF00D, 32'h0};
        vecs[5] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0050, 32'h0,        1'b1, 16'h0050, 1'b0, 32'h0,        32'hCAFEF00D};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 32'h0,        1'b1, 16'h0010, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[7] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0030, 32'h0,        1'b0, 16'h0040, 1'b0, 32'h0,        32'h0BADF00D};

        rst_f     = 1'b0;
        mem_clear = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset m_en", {31'b0, m_en}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset acks", {30'b0, if_ack, d_ack}, 32'd0);
        check("reset m_addr", {16'b0, m_addr}, 32'd0);
        check("reset m_wdata", m_wdata, 32'd0);
        check("reset rdata", if_rdata | d_rdata, 32'd0);
        @(negedge clk);
        rst_f     = 1'b1;
        mem_clear = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset dropped in the middle of ACC aborts the access.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 16'h0010;
        @(posedge clk); #1;
        check("mrst m_en acc", {31'b0, m_en}, 32'd1);
        #2;
        rst_f = 1'b0;
        #1;
        check("mrst m_en async", {31'b0, m_en}, 32'd0);
        check("mrst busy async", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check("mrst no ack", {30'b0, if_ack, d_ack}, 32'd0);
        @(negedge clk);
        rst_f = 1'b1;
        @(posedge clk); #1;
        check("mrst regrant m_en", {31'b0, m_en}, 32'd1);
        check("mrst regrant addr", {16'b0, m_addr}, 32'h10);
        @(posedge clk); #1;
        check("mrst if_ack", {30'b0, if_ack, d_ack}, 32'd2);
        check("mrst if_rdata", if_rdata, 32'hDEADBEEF);
        @(negedge clk);
        drop_reqs();
        @(posedge clk); #1;
        check("mrst busy idle", {31'b0, busy}, 32'd0);

        // Contention: both held continuously, starting from a cleared streak.
        exp_src = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 16'h0010;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0040;
        got     = 0;
        cyc     = 0;
        last_f  = 0;
        while (got < 6 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (if_ack || d_ack) begin
                check($sformatf("cont grant%0d", got), {30'b0, if_ack, d_ack}, {30'b0, exp_src[got]});
                if (if_ack) begin
                    check($sformatf("cont fetch gap%0d", got), {31'b0, (cyc - last_f) <= 9}, 32'd1);
                    check($sformatf("cont if_rdata%0d", got), if_rdata, 32'hDEADBEEF);
                    last_f = cyc;
                end else begin
                    check($sformatf("cont d_rdata%0d", got), d_rdata, 32'h0BADF00D);
                end
                got++;
            end
        end
        check("cont grants seen", got, 32'd6);
        @(negedge clk);
        drop_reqs();
        @(posedge clk); #1;
        check("cont busy idle", {31'b0, busy}, 32'd0);

        // Data request withdrawn during ACC still completes.
        @(negedge clk);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0020;
        @(posedge clk); #1;
        check("drop m_en", {31'b0, m_en}, 32'd1);
        @(negedge clk);
        drop_reqs();
        @(posedge clk); #1;
        check("drop d_ack", {30'b0, if_ack, d_ack}, 32'd1);
        check("drop d_rdata", d_rdata, 32'h12345678);
        @(posedge clk); #1;
        check("drop busy idle", {31'b0, busy}, 32'd0);

        // Request still high after its ack is taken as a new request.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 16'h0030;
        @(posedge clk); #1;
        check("held m_en 1", {31'b0, m_en}, 32'd1);
        @(posedge clk); #1;
        check("held ack 1", {31'b0, if_ack}, 32'd1);
        @(posedge clk); #1;
        check("held idle", {30'b0, busy, if_ack}, 32'd0);
        @(posedge clk); #1;
        check("held m_en 2", {31'b0, m_en}, 32'd1);
        @(negedge clk);
        drop_reqs();
        @(posedge clk); #1;
        check("held ack 2", {31'b0, if_ack}, 32'd1);
        check("held if_rdata 2", if_rdata, 32'hA5A5A5A5);
        @(posedge clk); #1;
        check("held busy end", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arb
`default_nettype wire
